// File: rtl/scc_pkg.sv
// Shared constants and types for the SCC wave-memory slice.
// Table geometry, channel ids and the value returned for reads of nonexistent tables.
package scc_pkg;

  localparam int SCC_WAVE_CHANNELS   = 5;
  localparam int SCC_WAVE_DEPTH_LOG2 = 5;
  localparam int SCC_WAVE_WORDS      = SCC_WAVE_CHANNELS << SCC_WAVE_DEPTH_LOG2;

  localparam logic [2:0] SCC_CH_A = 3'd0;
  localparam logic [2:0] SCC_CH_B = 3'd1;
  localparam logic [2:0] SCC_CH_C = 3'd2;
  localparam logic [2:0] SCC_CH_D = 3'd3;
  localparam logic [2:0] SCC_CH_E = 3'd4;

  localparam logic [7:0] SCC_INVALID_READ = 8'hFF;

  typedef enum logic {
    WAVE_CLEAR,
    WAVE_RUN
  } wave_state_e;

endpackage

// File: rtl/scc_wave_ram.sv
// Single-port synchronous RAM with registered read and no reset.
// Kept as its own module so a vendor block RAM can drop in.
module scc_wave_ram #(
  parameter int WORDS = 160,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [WORDS];
  logic [7:0] rdata_q;

  // Read-before-write; a read of a location written last cycle sees the new byte.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scc_wave_memory.sv
// Wave-table RAM responder: CPU requests via a 1-deep pending latch, tone fetches
// with fixed 2-cycle latency, and a post-reset clear sweep.
module scc_wave_memory
  import scc_pkg::*;
#(
  parameter int CHANNELS       = SCC_WAVE_CHANNELS,
  parameter int DEPTH_LOG2     = SCC_WAVE_DEPTH_LOG2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            sram_id,
  input  logic [DEPTH_LOG2-1:0] sram_a,
  input  logic [7:0]            sram_d,
  input  logic                  sram_oe,
  input  logic                  sram_we,
  output logic [7:0]            sram_q,
  output logic                  sram_q_en,
  input  logic                  share_de,
  input  logic                  wave_rd_req,
  input  logic [2:0]            wave_rd_id,
  input  logic [DEPTH_LOG2-1:0] wave_rd_a,
  output logic [7:0]            wave_rd_data,
  output logic                  wave_rd_valid,
  output logic                  busy
);

  localparam int WORDS = CHANNELS << DEPTH_LOG2;
  localparam int AW    = $clog2(WORDS);

  function automatic logic [AW-1:0] lin_idx(input logic [2:0] id,
                                            input logic [DEPTH_LOG2-1:0] a);
    lin_idx = AW'((int'(id) << DEPTH_LOG2) + int'(a));
  endfunction

  wave_state_e           state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_we_q, pend_we_d;
  logic [2:0]            pend_id_q, pend_id_d;
  logic [DEPTH_LOG2-1:0] pend_a_q, pend_a_d;
  logic [7:0]            pend_d_q, pend_d_d;
  logic                  s1_tone_q, s1_tone_d;
  logic                  s1_cpu_q, s1_cpu_d;
  logic                  s1_zero_q, s1_zero_d;
  logic                  s1_ff_q, s1_ff_d;
  logic [7:0]            sram_q_q, sram_q_d;
  logic                  sram_q_en_q, sram_q_en_d;
  logic [7:0]            wave_rd_data_q, wave_rd_data_d;
  logic                  wave_rd_valid_q, wave_rd_valid_d;

  logic                  ram_we_req;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [7:0]            ram_wdata;
  logic [7:0]            ram_rdata;
  logic [2:0]            tone_id_eff;
  logic                  tone_ok;
  logic                  cpu_ok;
  logic                  cpu_grant;

  always_comb begin
    state_d         = state_q;
    clr_cnt_d       = clr_cnt_q;
    busy_d          = busy_q;
    pend_valid_d    = pend_valid_q;
    pend_we_d       = pend_we_q;
    pend_id_d       = pend_id_q;
    pend_a_d        = pend_a_q;
    pend_d_d        = pend_d_q;
    s1_tone_d       = 1'b0;
    s1_cpu_d        = 1'b0;
    s1_zero_d       = 1'b0;
    s1_ff_d         = 1'b0;
    sram_q_d        = sram_q_q;
    sram_q_en_d     = 1'b0;
    wave_rd_data_d  = wave_rd_data_q;
    wave_rd_valid_d = 1'b0;
    ram_we_req      = 1'b0;
    ram_addr        = '0;
    ram_wdata       = 8'h00;

    tone_id_eff = (share_de && wave_rd_id == SCC_CH_E) ? SCC_CH_D : wave_rd_id;
    tone_ok     = int'(tone_id_eff) < CHANNELS;
    cpu_ok      = int'(pend_id_q) < CHANNELS;
    cpu_grant   = (state_q == WAVE_RUN) && pend_valid_q && !wave_rd_req;

    // A new request always wins the latch; the old one is granted this cycle if it can be.
    if (sram_oe || sram_we) begin
      pend_valid_d = 1'b1;
      pend_we_d    = sram_we;
      pend_id_d    = sram_id;
      pend_a_d     = sram_a;
      pend_d_d     = sram_d;
    end else if (cpu_grant) begin
      pend_valid_d = 1'b0;
    end

    case (state_q)
      WAVE_CLEAR: begin
        ram_we_req = 1'b1;
        ram_addr   = clr_cnt_q;
        clr_cnt_d  = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(WORDS - 1)) begin
          state_d   = WAVE_RUN;
          busy_d    = 1'b0;
          clr_cnt_d = '0;
        end
        if (wave_rd_req) begin
          s1_tone_d = 1'b1;
          s1_zero_d = 1'b1;
        end
      end
      default: begin
        if (wave_rd_req) begin
          s1_tone_d = 1'b1;
          if (tone_ok) begin
            ram_addr = lin_idx(tone_id_eff, wave_rd_a);
          end else begin
            s1_ff_d = 1'b1;
          end
        end else if (cpu_grant) begin
          if (cpu_ok) begin
            ram_addr = lin_idx(pend_id_q, pend_a_q);
          end
          if (pend_we_q) begin
            ram_we_req = cpu_ok;
            ram_wdata  = pend_d_q;
          end else begin
            s1_cpu_d = 1'b1;
            s1_ff_d  = !cpu_ok;
          end
        end
      end
    endcase

    // Second pipeline stage: RAM data is ready, capture into the output registers.
    if (s1_tone_q) begin
      wave_rd_valid_d = 1'b1;
      wave_rd_data_d  = s1_zero_q ? 8'h00 : (s1_ff_q ? SCC_INVALID_READ : ram_rdata);
    end
    if (s1_cpu_q) begin
      sram_q_en_d = 1'b1;
      sram_q_d    = s1_ff_q ? SCC_INVALID_READ : ram_rdata;
    end
  end

  assign ram_we = ram_we_req && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= CLEAR_ON_RESET ? WAVE_CLEAR : WAVE_RUN;
      clr_cnt_q       <= '0;
      busy_q          <= CLEAR_ON_RESET;
      pend_valid_q    <= 1'b0;
      pend_we_q       <= 1'b0;
      pend_id_q       <= '0;
      pend_a_q        <= '0;
      pend_d_q        <= 8'h00;
      s1_tone_q       <= 1'b0;
      s1_cpu_q        <= 1'b0;
      s1_zero_q       <= 1'b0;
      s1_ff_q         <= 1'b0;
      sram_q_q        <= 8'h00;
      sram_q_en_q     <= 1'b0;
      wave_rd_data_q  <= 8'h00;
      wave_rd_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      busy_q          <= busy_d;
      pend_valid_q    <= pend_valid_d;
      pend_we_q       <= pend_we_d;
      pend_id_q       <= pend_id_d;
      pend_a_q        <= pend_a_d;
      pend_d_q        <= pend_d_d;
      s1_tone_q       <= s1_tone_d;
      s1_cpu_q        <= s1_cpu_d;
      s1_zero_q       <= s1_zero_d;
      s1_ff_q         <= s1_ff_d;
      sram_q_q        <= sram_q_d;
      sram_q_en_q     <= sram_q_en_d;
      wave_rd_data_q  <= wave_rd_data_d;
      wave_rd_valid_q <= wave_rd_valid_d;
    end
  end

  scc_wave_ram #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign sram_q        = sram_q_q;
  assign sram_q_en     = sram_q_en_q;
  assign wave_rd_data  = wave_rd_data_q;
  assign wave_rd_valid = wave_rd_valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_scc_wave_memory.sv
// Scoreboard bench for scc_wave_memory: a table-level model predicts each strobe's
// data and arrival cycle; a negedge monitor pops and compares.
module tb_scc_wave_memory;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sram_id;
  logic [4:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_oe;
  logic       sram_we;
  logic [7:0] sram_q;
  logic       sram_q_en;
  logic       share_de;
  logic       wave_rd_req;
  logic [2:0] wave_rd_id;
  logic [4:0] wave_rd_a;
  logic [7:0] wave_rd_data;
  logic       wave_rd_valid;
  logic       busy;

  always #5 clk = ~clk;

  scc_wave_memory dut (
    .clk           (clk),
    .reset         (reset),
    .sram_id       (sram_id),
    .sram_a        (sram_a),
    .sram_d        (sram_d),
    .sram_oe       (sram_oe),
    .sram_we       (sram_we),
    .sram_q        (sram_q),
    .sram_q_en     (sram_q_en),
    .share_de      (share_de),
    .wave_rd_req   (wave_rd_req),
    .wave_rd_id    (wave_rd_id),
    .wave_rd_a     (wave_rd_a),
    .wave_rd_data  (wave_rd_data),
    .wave_rd_valid (wave_rd_valid),
    .busy          (busy)
  );

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       tone_q[$];
  exp_t       cpu_q[$];
  logic [7:0] ref_mem [160];
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  bit         chk_en = 1'b0;
  logic       exp_busy = 1'b0;
  int         clear_left = 0;
  bit         pend_v = 1'b0;
  bit         pend_we = 1'b0;
  int         pend_id = 0;
  int         pend_a = 0;
  logic [7:0] pend_d = 8'h00;

  always @(posedge clk) cyc++;

  // Drive one cycle of inputs and advance the reference model by that cycle.
  task automatic applyStimulus(input bit rst, input bit oe, input bit we, input int id,
                               input int a, input logic [7:0] d, input bit treq,
                               input int tid, input int ta, input bit sh);
    exp_t e;
    int   eff;
    bit   clearing;
    reset       = rst;
    sram_oe     = oe;
    sram_we     = we;
    sram_id     = 3'(id);
    sram_a      = 5'(a);
    sram_d      = d;
    wave_rd_req = treq;
    wave_rd_id  = 3'(tid);
    wave_rd_a   = 5'(ta);
    share_de    = sh;
    clearing    = clear_left > 0;
    exp_busy    = clearing;
    if (rst) begin
      while (tone_q.size() > 0 && tone_q[$].due > cyc) void'(tone_q.pop_back());
      while (cpu_q.size() > 0 && cpu_q[$].due > cyc) void'(cpu_q.pop_back());
      clear_left = 160;
      pend_v     = 1'b0;
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    end else begin
      if (treq) begin
        eff   = (sh && tid == 4) ? 3 : tid;
        e.due = cyc + 2;
        if (clearing) e.data = 8'h00;
        else if (eff >= 5) e.data = 8'hFF;
        else e.data = ref_mem[eff * 32 + ta];
        tone_q.push_back(e);
      end
      if (pend_v && !treq && !clearing) begin
        if (pend_we) begin
          if (pend_id < 5) ref_mem[pend_id * 32 + pend_a] = pend_d;
        end else begin
          e.due  = cyc + 2;
          e.data = (pend_id < 5) ? ref_mem[pend_id * 32 + pend_a] : 8'hFF;
          cpu_q.push_back(e);
        end
        pend_v = 1'b0;
      end
      if (oe || we) begin
        pend_v  = 1'b1;
        pend_we = we;
        pend_id = id;
        pend_a  = a;
        pend_d  = d;
      end
      if (clearing) clear_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic cpuOp(input bit oe, input bit we, input int id, input int a,
                       input logic [7:0] d);
    applyStimulus(0, oe, we, id, a, d, 0, 0, 0, 0);
  endtask

  task automatic toneRd(input int id, input int a, input bit sh);
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 1, id, a, sh);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (busy === exp_busy) passes++;
    else $display("[TB] FAIL busy cycle %0d: got %b expected %b", cyc, busy, exp_busy);
    while (tone_q.size() > 0 && tone_q[0].due < cyc) begin
      e = tone_q.pop_front();
      checks++;
      $display("[TB] FAIL tone_missing cycle %0d: no strobe, expected %02h due %0d", cyc, e.data, e.due);
    end
    while (cpu_q.size() > 0 && cpu_q[0].due < cyc) begin
      e = cpu_q.pop_front();
      checks++;
      $display("[TB] FAIL cpu_missing cycle %0d: no strobe, expected %02h due %0d", cyc, e.data, e.due);
    end
    if (wave_rd_valid === 1'b1) begin
      checks++;
      if (tone_q.size() == 0) begin
        $display("[TB] FAIL tone_unexpected cycle %0d: strobe with %02h, none expected", cyc, wave_rd_data);
      end else begin
        e = tone_q.pop_front();
        if (e.due == cyc && wave_rd_data === e.data) passes++;
        else $display("[TB] FAIL tone_data cycle %0d: got %02h expected %02h due %0d", cyc, wave_rd_data, e.data, e.due);
      end
    end
    if (sram_q_en === 1'b1) begin
      checks++;
      if (cpu_q.size() == 0) begin
        $display("[TB] FAIL cpu_unexpected cycle %0d: strobe with %02h, none expected", cyc, sram_q);
      end else begin
        e = cpu_q.pop_front();
        if (e.due == cyc && sram_q === e.data) passes++;
        else $display("[TB] FAIL cpu_data cycle %0d: got %02h expected %02h due %0d", cyc, sram_q, e.data, e.due);
      end
    end
  endtask

  always @(negedge clk) if (chk_en) checkOutput();

  initial begin
    int gap;
    int op;
    bit doCpu;
    $display("[TB] start");
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    chk_en = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);

    // Tone reads during the sweep read as zero; a CPU write waits for RUN.
    idle(10);
    toneRd(2, 3, 0);
    toneRd(7, 3, 0);
    cpuOp(0, 1, 1, 7, 8'h77);
    idle(170);

    for (int id = 0; id < 5; id++) begin
      cpuOp(1, 0, id, 0, 8'h00);
      idle(3);
      cpuOp(1, 0, id, 31, 8'h00);
      idle(3);
    end

    cpuOp(0, 1, 2, 5, 8'hA5);
    idle(3);
    cpuOp(1, 0, 2, 5, 8'h00);
    idle(3);

    // CPU read held off by three back-to-back tone fetches.
    applyStimulus(0, 1, 0, 1, 7, 8'h00, 1, 2, 5, 0);
    toneRd(1, 7, 0);
    toneRd(0, 0, 0);
    idle(4);

    cpuOp(0, 1, 3, 0, 8'h3C);
    idle(3);
    toneRd(4, 0, 1);
    toneRd(4, 0, 0);
    idle(3);

    cpuOp(0, 1, 6, 0, 8'h55);
    idle(3);
    cpuOp(1, 1, 6, 9, 8'h66);
    idle(3);
    cpuOp(1, 0, 6, 0, 8'h00);
    idle(3);
    for (int i = 0; i < 160; i++) toneRd(i / 32, i % 32, 0);
    idle(3);

    gap = 0;
    for (int n = 0; n < 600; n++) begin
      doCpu = (gap >= 4) && ($urandom_range(0, 2) == 0);
      op    = $urandom_range(0, 3);
      applyStimulus(0, doCpu && (op != 2), doCpu && (op >= 2),
                    $urandom_range(0, 7), $urandom_range(0, 31), 8'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7),
                    $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      gap = doCpu ? 0 : gap + 1;
    end
    idle(4);

    // Reset between a read grant and its strobe: strobe dropped, sweep restarts.
    cpuOp(0, 1, 2, 5, 8'hC3);
    idle(3);
    cpuOp(1, 0, 2, 5, 8'h00);
    idle(1);
    applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    idle(20);
    toneRd(2, 5, 0);
    idle(145);
    cpuOp(1, 0, 2, 5, 8'h00);
    idle(3);
    toneRd(2, 5, 0);
    idle(5);

    checks++;
    if (tone_q.size() == 0) passes++;
    else $display("[TB] FAIL tone_drain: %0d strobes outstanding, expected 0", tone_q.size());
    checks++;
    if (cpu_q.size() == 0) passes++;
    else $display("[TB] FAIL cpu_drain: %0d strobes outstanding, expected 0", cpu_q.size());

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/scc_wave_memory.md
Name: scc_wave_memory

Overview:
- Responder side of the sram_* wave-memory interface driven by scc_register; holds the 5 x 32-byte SCC/SCC-I waveform RAM.
- Serves CPU-side requests (sram_oe/sram_we pulses, read data returned on sram_q/sram_q_en) and the tone generator's per-slot sample fetches from a single-port RAM.
- Contents are cleared after reset by an internal sweep.

Parameters:
- CHANNELS, 5, number of wave tables (ids 0..CHANNELS-1 valid)
- DEPTH_LOG2, 5, address bits per table (32 bytes)
- CLEAR_ON_RESET, 1, 1 = sweep RAM to 8'h00 after reset; 0 = skip the CLEAR state

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sram_id  in  3  CPU-side table select (0=A .. 4=E)
- sram_a  in  5  CPU-side byte address
- sram_d  in  8  CPU-side write data
- sram_oe  in  1  CPU read request, single-cycle pulse
- sram_we  in  1  CPU write request, single-cycle pulse
- sram_q  out  8  CPU read data
- sram_q_en  out  1  one-cycle strobe, sram_q valid
- share_de  in  1  1 = SCC-compatible mode; tone reads of id 4 are redirected to id 3
- wave_rd_req  in  1  tone-generator fetch request
- wave_rd_id  in  3  tone-generator table select
- wave_rd_a  in  5  tone-generator sample address
- wave_rd_data  out  8  fetched sample
- wave_rd_valid  out  1  one-cycle strobe, wave_rd_data valid
- busy  out  1  high while the CLEAR sweep runs

Behaviour:
- Reset values: sram_q=0, sram_q_en=0, wave_rd_data=0, wave_rd_valid=0, busy=CLEAR_ON_RESET, pending latch empty, clear counter=0.
- FSM states:
  - CLEAR: entered on reset when CLEAR_ON_RESET=1. Each cycle writes 8'h00 to RAM[counter], then counter+1. After counter=CHANNELS*32-1 (159) is written, the next state is RUN and busy falls. Sweep lasts 160 cycles.
  - RUN: entered directly from reset when CLEAR_ON_RESET=0.
- RAM: single port, linear index = id*32 + a. Synchronous read with 1-cycle RAM latency, followed by an output register. Total latency from grant to strobe is 2 cycles.
- Tone port priority:
  - In RUN, wave_rd_req is granted in the cycle it is asserted.
  - wave_rd_valid is asserted exactly 2 cycles after wave_rd_req. This fixed latency is mandatory; the tone pipeline relies on it.
  - In CLEAR, a tone request still produces wave_rd_valid at +2, with data 8'h00.
- CPU request handling:
  - Any cycle with sram_oe|sram_we loads a 1-deep pending latch (id, a, d, op).
  - The pending request is granted in the first RUN cycle with no wave_rd_req, then the latch empties.
  - A new CPU request while pending overwrites the latch. The older request is lost. The bus contract keeps requests at least 4 cycles apart, so this does not occur in normal use.
  - A CPU request and a pending grant in the same cycle: the new request is latched and the old one is granted.
- Write grant:
  - RAM written in the grant cycle.
  - No sram_q_en.
  - A read of the same location granted the next cycle returns the new data.
- Read grant: sram_q is updated and sram_q_en pulses one cycle, 2 cycles after the grant. sram_q holds its value otherwise.
- sram_oe and sram_we asserted together: treated as a write; no sram_q_en.
- Invalid id (>= CHANNELS), on either port:
  - writes are ignored;
  - reads complete with normal latency and return 8'hFF.
- share_de is sampled at tone-grant time. It only affects the tone port; the CPU port always uses sram_id as given.
- Reset asserted mid-operation:
  - pending latch, pipeline valid bits and outputs return to their reset values;
  - the FSM restarts CLEAR at counter 0;
  - any in-flight strobes are suppressed.

Decomposition:
- Shared package scc_pkg: SCC_WAVE_CHANNELS=5, SCC_WAVE_DEPTH_LOG2=5, SCC_WAVE_WORDS=160, channel id constants (SCC_CH_A..SCC_CH_E), SCC_INVALID_READ=8'hFF.
- One sub-module: scc_wave_ram, a single-port synchronous RAM (160x8, registered read) with no reset. It is kept separate so vendor block RAM can be substituted.
- The FSM, pending latch, arbiter and output pipeline live in scc_wave_memory.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy high for exactly 160 cycles; afterwards, reads of id 0..4 at addresses 0 and 31 all return 8'h00.
- CPU write id=2, a=5, d=8'hA5; 4 cycles later CPU read id=2, a=5 -> sram_q=8'hA5, sram_q_en pulses exactly 2 cycles after the grant cycle.
- wave_rd_req held high for 3 cycles while a CPU read is pending -> wave_rd_valid at each +2 cycles; the CPU read is granted in the first idle cycle, with sram_q_en 2 cycles later.
- Write id=3, a=0, d=8'h3C; tone read id=4, a=0 with share_de=1 -> 8'h3C; same read with share_de=0 -> 8'h00.
- CPU write id=6 d=8'h55, then read id=6 -> no RAM change (full readback of 160 bytes unchanged), read returns 8'hFF with sram_q_en.
- Assert reset for 1 cycle between a CPU read grant and its strobe -> no sram_q_en; busy=1; the CLEAR sweep restarts from 0.
